// File: rtl/gba_video_pkg.sv
// Shared definitions for the GBA video path: frame geometry, the capture
// state type and the BGR555 -> RGB666 colour expansion.
package gba_video_pkg;

  localparam int GBA_WIDTH  = 240;
  localparam int GBA_HEIGHT = 160;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } cap_state_t;

  // Widen each 5-bit channel to 6 bits by replicating its MSB, so full
  // scale maps to full scale (31 -> 63) and zero stays zero.
  function automatic logic [17:0] bgr555_to_rgb666(input logic [14:0] color);
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    r = color[4:0];
    g = color[9:5];
    b = color[14:10];
    return {r, r[4], g, g[4], b, b[4]};
  endfunction

endpackage

// File: rtl/gba_video_capture.sv
// Captures the PPU pixel stream, tags each pixel with its frame position,
// expands it to RGB666 and issues one framebuffer write per pixel through a
// two-stage pipeline. Also polices frame length, supports freezing the
// displayed picture and counts complete frames.
module gba_video_capture
  import gba_video_pkg::*;
#(
  parameter int WIDTH  = GBA_WIDTH,
  parameter int HEIGHT = GBA_HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        ppu_valid,
  input  logic [14:0] ppu_color,
  output logic        ppu_ready,
  input  logic        freeze,
  output logic [17:0] pixel_data,
  output logic [7:0]  pixel_x,
  output logic [7:0]  pixel_y,
  output logic        pixel_we,
  output logic        frame_done,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] frame_count
);

  localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

  cap_state_t state, state_next;
  logic [7:0] x, x_next;
  logic [7:0] y, y_next;
  logic       frozen, frozen_next;

  // Position and freeze status that apply to a pixel accepted this cycle,
  // after any coincident frame_start restart has been applied.
  logic [7:0] cur_x, cur_y;
  logic       cur_frozen;
  logic       in_frame;
  logic       take;
  logic       take_last;
  logic       short_set;
  logic       long_set;
  logic       accept;

  // Stage 1 registers
  logic        s1_valid;
  logic [14:0] s1_color;
  logic [7:0]  s1_x;
  logic [7:0]  s1_y;
  logic        s1_last;
  logic        s1_frozen;

  assign accept = ppu_valid & ppu_ready;

  // Next-state logic: frame_start restarts first, then any accepted pixel
  // is placed at the (possibly restarted) position.
  always_comb begin
    state_next  = state;
    x_next      = x;
    y_next      = y;
    frozen_next = frozen;
    cur_x       = x;
    cur_y       = y;
    cur_frozen  = frozen;
    in_frame    = (state == ACTIVE);
    take        = 1'b0;
    take_last   = 1'b0;
    short_set   = 1'b0;
    long_set    = 1'b0;

    if (frame_start) begin
      if ((state == ACTIVE) && ((x != 8'd0) || (y != 8'd0))) begin
        short_set = 1'b1;
      end
      state_next  = ACTIVE;
      cur_x       = 8'd0;
      cur_y       = 8'd0;
      x_next      = 8'd0;
      y_next      = 8'd0;
      frozen_next = freeze;
      cur_frozen  = freeze;
      in_frame    = 1'b1;
    end

    if (accept) begin
      if (in_frame) begin
        take = 1'b1;
        if (cur_x == X_MAX) begin
          x_next = 8'd0;
          if (cur_y == Y_MAX) begin
            take_last  = 1'b1;
            y_next     = 8'd0;
            state_next = DONE;
          end else begin
            y_next = cur_y + 8'd1;
          end
        end else begin
          x_next = cur_x + 8'd1;
        end
      end else if (state == DONE) begin
        long_set = 1'b1;
      end
    end
  end

  // Control state, position counters, freeze latch, ready and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      x         <= 8'd0;
      y         <= 8'd0;
      frozen    <= 1'b0;
      ppu_ready <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      frozen    <= frozen_next;
      ppu_ready <= 1'b1;
      if (short_set) err_short <= 1'b1;
      if (long_set)  err_long  <= 1'b1;
    end
  end

  // Stage 1: capture the raw pixel with its position and freeze status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_color  <= 15'd0;
      s1_x      <= 8'd0;
      s1_y      <= 8'd0;
      s1_last   <= 1'b0;
      s1_frozen <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) begin
        s1_color  <= ppu_color;
        s1_x      <= cur_x;
        s1_y      <= cur_y;
        s1_last   <= take_last;
        s1_frozen <= cur_frozen;
      end
    end
  end

  // Stage 2: expand colour and drive the write bus; frame statistics keep
  // running even when writes are suppressed by freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_we    <= 1'b0;
      pixel_data  <= 18'd0;
      pixel_x     <= 8'd0;
      pixel_y     <= 8'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      pixel_we   <= s1_valid & ~s1_frozen;
      frame_done <= s1_valid & s1_last;
      if (s1_valid & ~s1_frozen) begin
        pixel_data <= bgr555_to_rgb666(s1_color);
        pixel_x    <= s1_x;
        pixel_y    <= s1_y;
      end
      if (s1_valid & s1_last) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gba_video_capture.sv
// Randomized scoreboard bench for gba_video_capture. A pixel-index model
// predicts every write / frame_done event; a monitor pops and compares.
module tb_gba_video_capture;

  localparam int W = 240;
  localparam int H = 160;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        ppu_valid = 1'b0;
  logic [14:0] ppu_color = 15'd0;
  logic        ppu_ready;
  logic        freeze = 1'b0;
  logic [17:0] pixel_data;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic        pixel_we;
  logic        frame_done;
  logic        err_short;
  logic        err_long;
  logic [15:0] frame_count;

  gba_video_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .ppu_valid(ppu_valid), .ppu_color(ppu_color), .ppu_ready(ppu_ready),
    .freeze(freeze), .pixel_data(pixel_data), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_we(pixel_we), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          we;
    bit          done;
    logic [17:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
    int          at;
  } exp_t;

  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  // Reference model: frame progress as a linear pixel index.
  // -1 = waiting for frame_start, 0..NPIX-1 = next pixel, NPIX = frame complete.
  int          m_idx = -1;
  bit          m_frozen = 0;
  bit          m_short = 0;
  bit          m_long = 0;
  int          m_count = 0;
  int          m_we_total = 0;
  logic [17:0] m_last_data = 18'd0;
  logic [7:0]  m_last_x = 8'd0;
  logic [7:0]  m_last_y = 8'd0;
  int          seen_we = 0;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Each 5-bit channel scaled to 6 bits: 2*c plus one when c is in the upper half.
  function automatic logic [17:0] expand(input logic [14:0] c);
    int r, g, b, r6, g6, b6;
    r = int'(c) % 32;
    g = (int'(c) / 32) % 32;
    b = (int'(c) / 1024) % 32;
    r6 = 2 * r + ((r >= 16) ? 1 : 0);
    g6 = 2 * g + ((g >= 16) ? 1 : 0);
    b6 = 2 * b + ((b >= 16) ? 1 : 0);
    return 18'(r6 * 4096 + g6 * 64 + b6);
  endfunction

  // Drive one cycle of inputs and advance the model accordingly.
  task automatic step(input bit fs, input bit fz, input bit v, input logic [14:0] col);
    exp_t e;
    @(posedge clk); #1;
    frame_start = fs;
    freeze      = fz;
    ppu_valid   = v;
    ppu_color   = col;
    if (fs) begin
      if (m_idx > 0 && m_idx < NPIX) m_short = 1;
      m_idx = 0;
      m_frozen = fz;
    end
    if (v) begin
      if (m_idx >= 0 && m_idx < NPIX) begin
        e.we   = !m_frozen;
        e.done = (m_idx == NPIX - 1);
        e.data = expand(col);
        e.x    = 8'(m_idx % W);
        e.y    = 8'(m_idx / W);
        e.at   = cyc + 2;
        if (e.we) begin
          m_we_total++;
          m_last_data = e.data;
          m_last_x = e.x;
          m_last_y = e.y;
        end
        if (e.we || e.done) sb.push_back(e);
        if (e.done) m_count = (m_count + 1) % 65536;
        m_idx++;
      end else if (m_idx == NPIX) begin
        m_long = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 15'd0);
  endtask

  task automatic check_status(input string tag);
    chk(sb.size() == 0, {tag, "_drained"}, $sformatf("%0d pending", sb.size()), "0 pending");
    chk(frame_count == 16'(m_count), {tag, "_frame_count"}, $sformatf("%0d", frame_count), $sformatf("%0d", m_count));
    chk(err_short == m_short, {tag, "_err_short"}, $sformatf("%0b", err_short), $sformatf("%0b", m_short));
    chk(err_long == m_long, {tag, "_err_long"}, $sformatf("%0b", err_long), $sformatf("%0b", m_long));
    chk(seen_we == m_we_total, {tag, "_we_total"}, $sformatf("%0d", seen_we), $sformatf("%0d", m_we_total));
  endtask

  task automatic check_reset_values(input string tag);
    chk(ppu_ready == 1'b0, {tag, "_ppu_ready"}, $sformatf("%0b", ppu_ready), "0");
    chk(pixel_we == 1'b0 && frame_done == 1'b0, {tag, "_strobes"},
        $sformatf("we=%0b done=%0b", pixel_we, frame_done), "we=0 done=0");
    chk(pixel_data == 18'd0 && pixel_x == 8'd0 && pixel_y == 8'd0, {tag, "_bus"},
        $sformatf("%05h (%0d,%0d)", pixel_data, pixel_x, pixel_y), "00000 (0,0)");
    chk(err_short == 1'b0 && err_long == 1'b0 && frame_count == 16'd0, {tag, "_stats"},
        $sformatf("short=%0b long=%0b count=%0d", err_short, err_long, frame_count),
        "short=0 long=0 count=0");
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    frame_start = 1'b0;
    ppu_valid = 1'b0;
    sb.delete();
    m_idx = -1; m_frozen = 0; m_short = 0; m_long = 0; m_count = 0;
    m_we_total = 0; seen_we = 0;
    m_last_data = 18'd0; m_last_x = 8'd0; m_last_y = 8'd0;
    #2;
    check_reset_values(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk(ppu_ready == 1'b1, {tag, "_ready_rise"}, $sformatf("%0b", ppu_ready), "1");
  endtask

  // Monitor: every write or frame_done event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (pixel_we || frame_done)) begin
      if (pixel_we) seen_we++;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_output",
            $sformatf("we=%0b done=%0b (%0d,%0d) cyc %0d", pixel_we, frame_done, pixel_x, pixel_y, cyc),
            "no output");
      end else begin
        exp_t e;
        bit ok;
        e = sb.pop_front();
        ok = (pixel_we == e.we) && (frame_done == e.done) && (cyc == e.at) &&
             (!e.we || (pixel_data == e.data && pixel_x == e.x && pixel_y == e.y));
        chk(ok, "write",
            $sformatf("we=%0b done=%0b %05h (%0d,%0d) cyc %0d", pixel_we, frame_done, pixel_data, pixel_x, pixel_y, cyc),
            $sformatf("we=%0b done=%0b %05h (%0d,%0d) cyc %0d", e.we, e.done, e.data, e.x, e.y, e.at));
      end
    end
  end

  initial begin
    int start_we;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk(ppu_ready == 1'b1, "por_ready_rise", $sformatf("%0b", ppu_ready), "1");

    // Pixels before any frame_start are discarded.
    repeat (6) step(0, 0, 1, 15'($urandom));
    idle(4);
    check_status("sync");

    // Full white frame, back to back; frame_start coincides with the first pixel.
    step(1, 0, 1, 15'h7FFF);
    repeat (NPIX - 1) step(0, 0, 1, 15'h7FFF);
    idle(4);
    check_status("white_frame");
    chk(seen_we == NPIX, "white_we_count", $sformatf("%0d", seen_we), $sformatf("%0d", NPIX));

    // Extras after frame completion are dropped and flagged.
    repeat (5) step(0, 0, 1, 15'($urandom));
    idle(4);
    check_status("extras");

    // Known colours at the start of a frame, then a short random-paced frame.
    step(1, 0, 0, 15'd0);
    step(0, 0, 1, 15'h001F);
    step(0, 0, 1, 15'h4210);
    while (m_idx < 1000) step(0, 0, ($urandom_range(0, 3) != 0), 15'($urandom));
    idle(3);
    chk(err_short == 1'b0, "pre_restart_short", $sformatf("%0b", err_short), "0");
    // Restart coincident with a pixel: that pixel lands at (0,0).
    step(1, 0, 1, 15'($urandom));
    repeat (20) step(0, 0, ($urandom_range(0, 1) != 0), 15'($urandom));
    idle(4);
    check_status("short_frame");

    // Frozen full frame: no writes, statistics still advance, bus holds.
    start_we = seen_we;
    step(1, 1, 1, 15'($urandom));
    repeat (NPIX - 1) step(0, 0, 1, 15'($urandom));
    idle(4);
    check_status("frozen_frame");
    chk(seen_we == start_we, "frozen_no_writes", $sformatf("%0d", seen_we - start_we), "0");
    chk(pixel_data == m_last_data && pixel_x == m_last_x && pixel_y == m_last_y, "frozen_hold",
        $sformatf("%05h (%0d,%0d)", pixel_data, pixel_x, pixel_y),
        $sformatf("%05h (%0d,%0d)", m_last_data, m_last_x, m_last_y));

    // Unfreeze restores writes.
    step(1, 0, 1, 15'($urandom));
    repeat (30) step(0, 0, ($urandom_range(0, 3) != 0), 15'($urandom));
    idle(4);
    check_status("unfrozen");

    // Reset mid-frame around pixel 500.
    step(1, 0, 0, 15'd0);
    while (m_idx < 500) step(0, 0, ($urandom_range(0, 3) != 0), 15'($urandom));
    do_reset("mid_reset");
    repeat (12) step(0, 0, 1, 15'($urandom));
    idle(4);
    check_status("post_reset_sync");
    step(1, 0, 1, 15'($urandom));
    repeat (15) step(0, 0, ($urandom_range(0, 3) != 0), 15'($urandom));
    idle(4);
    check_status("post_reset_frame");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gba_video_capture.md
# gba_video_capture

Upstream feeder for the HDMI converter. Accepts the GBA PPU's serial BGR555 pixel stream in the `clk` (GBA core) domain and expands each pixel to RGB666. Tags each pixel with its (x, y) position in the 240×160 frame and emits one framebuffer write per pixel on the `pixel_*` bus that the HDMI converter latches. It also:

- polices frame length,
- supports freezing the displayed picture,
- reports frame statistics.

## Interface
Parameters:
- `WIDTH`, 240, active pixels per line
- `HEIGHT`, 160, active lines per frame

Ports:
- `clk`  in  1  GBA core clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse marking start of a PPU frame (first pixel follows)
- `ppu_valid`  in  1  `ppu_color` holds a pixel
- `ppu_color`  in  15  BGR555: B[14:10], G[9:5], R[4:0]
- `ppu_ready`  out  1  pixel accepted when `ppu_valid & ppu_ready`
- `freeze`  in  1  request to hold current framebuffer contents
- `pixel_data`  out  18  RGB666: R[17:12], G[11:6], B[5:0]
- `pixel_x`  out  8  column 0..WIDTH-1
- `pixel_y`  out  8  line 0..HEIGHT-1
- `pixel_we`  out  1  write strobe, one cycle per pixel
- `frame_done`  out  1  one-cycle pulse after last pixel of a complete frame is written
- `err_short`  out  1  sticky: frame ended before WIDTH*HEIGHT pixels
- `err_long`  out  1  sticky: pixels arrived after frame complete
- `frame_count`  out  16  count of complete frames, wraps at 65535→0

## Operation
- FSM states: SYNC, ACTIVE, DONE. Reset state is SYNC.
  - SYNC: `ppu_ready`=1. Accepted pixels are discarded. `frame_start` → ACTIVE.
  - ACTIVE: `ppu_ready`=1. Each accepted pixel enters the pipeline at the current (x, y).
    - x increments and wraps WIDTH-1→0. When x wraps, y increments.
    - Acceptance at (WIDTH-1, HEIGHT-1) → DONE.
  - DONE: `ppu_ready`=1. Any accepted pixel sets `err_long` and is discarded. `frame_start` → ACTIVE.
  - `frame_start` in ACTIVE when the pixel count is nonzero sets `err_short`. It restarts at (0,0) and stays in ACTIVE.
- `frame_start` coincident with an accepted pixel: the restart takes effect first. That pixel is written at (0,0).
- `freeze` is sampled only on `frame_start` into `frozen`. While `frozen`=1, the pipeline runs but `pixel_we` is forced 0. `frame_done` and `frame_count` still update, so statistics keep running.
- Colour expansion: each 5-bit channel c → {c, c[4]}. So 0→0, 31→63, 16→33.
- Sticky errors clear only on `reset`.
- Reset values: `ppu_ready`=0, `pixel_we`=0, `pixel_data`=0, `pixel_x`=0, `pixel_y`=0, `frame_done`=0, `err_short`=0, `err_long`=0, `frame_count`=0, `frozen`=0, state SYNC, x=y=0.

## Timing
- Two-stage pipeline with no backpressure, so `ppu_ready`=1 in every non-reset cycle. `ppu_ready` rises on the first `clk` edge after `reset` deasserts.
  - Stage 1 registers colour, x, y and a valid bit.
  - Stage 2 registers the expanded data and `pixel_we`.
- Latency: pixel accepted at edge N → `pixel_we`=1 with its data/x/y valid after edge N+2. One write per cycle sustained.
- `frame_done` pulses in the same cycle as `pixel_we` for pixel (WIDTH-1, HEIGHT-1), even when frozen. `frame_count` increments on that same edge.
- `pixel_data`/`pixel_x`/`pixel_y` hold their last values when `pixel_we`=0.
- If `reset` asserts mid-frame, the pipeline valid bits clear asynchronously. No partial write appears after `reset` deasserts.

## Structure
- Package `gba_video_pkg`:
  - `GBA_WIDTH`=240 and `GBA_HEIGHT`=160 constants
  - `cap_state_t` enum (SYNC/ACTIVE/DONE)
  - `bgr555_to_rgb666` function
- The HDMI converter imports the same package for its frame dimensions.
- Single module; no sub-module warranted.

## Test plan
- Reset, then `frame_start` followed by 38400 back-to-back pixels of `ppu_color`=15'h7FFF:
  - 38400 `pixel_we` pulses, all with `pixel_data`=18'h3FFFF
  - last write at (239,159) with `frame_done` in the same cycle
  - `frame_count`=1
- Single pixel 15'h001F (R=31) at (0,0): `pixel_we` two cycles after acceptance; `pixel_data`=18'h3F000. 15'h4210 (16,16,16) → 18'h21861.
- `frame_start`, 1000 pixels, `frame_start` again: `err_short`=1; the next pixel is written at (0,0); `frame_count` unchanged.
- Full frame plus 5 extra pixels: `err_long`=1; no `pixel_we` for the extras; the state stays DONE until `frame_start`.
- `freeze`=1 at `frame_start`, full frame: zero `pixel_we`, `frame_done` still pulses, `frame_count` increments. `freeze`=0 at the next `frame_start` restores writes.
- Assert `reset` for 1 cycle at pixel 500: all outputs return to reset values. Pixels before the next `frame_start` produce no writes.
